// File: rtl/snn_tick_scheduler.sv
// Run-time sequencer for a 1x1 RANC SNN core: tracks configuration loading,
// issues a programmed number of spaced tick pulses, counts spikes, aborts on core errors.
module snn_tick_scheduler #(
  parameter int NUM_NEURONS = 256,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           clear_error,
  input  logic [CNT_W-1:0]               num_ticks,
  input  logic [CNT_W-1:0]               tick_period,
  input  logic                           param_wen,
  input  logic [$clog2(NUM_NEURONS)-1:0] param_address,
  input  logic                           neuron_inst_wen,
  input  logic [$clog2(NUM_NEURONS)-1:0] neuron_inst_address,
  input  logic                           input_buffer_empty,
  input  logic                           ren_to_input_buffer,
  input  logic                           packet_out_valid,
  input  logic                           token_controller_error,
  input  logic                           scheduler_error,
  output logic                           tick,
  output logic                           config_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [CNT_W-1:0]               tick_count,
  output logic [CNT_W-1:0]               spike_count
);

  localparam int AW = $clog2(NUM_NEURONS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TICK,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_ticks_q, num_ticks_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;
  logic [CNT_W-1:0] spike_count_q, spike_count_d;
  logic             param_loaded_q, param_loaded_d;
  logic             inst_loaded_q, inst_loaded_d;
  logic             config_ready_q, config_ready_d;

  logic run_err;
  logic counting;

  // Load flags are sticky; config_ready follows in the same edge as the setting write.
  always_comb begin
    param_loaded_d = param_loaded_q | (param_wen && (param_address == LAST_ADDR));
    inst_loaded_d  = inst_loaded_q | (neuron_inst_wen && (neuron_inst_address == LAST_ADDR));
    config_ready_d = param_loaded_d & inst_loaded_d;
  end

  assign run_err  = token_controller_error | scheduler_error | param_wen | neuron_inst_wen;
  assign counting = (state_q == S_DRAIN) || (state_q == S_TICK) ||
                    (state_q == S_WAIT) || (state_q == S_DONE);

  always_comb begin
    state_d       = state_q;
    num_ticks_d   = num_ticks_q;
    period_d      = period_q;
    wait_cnt_d    = wait_cnt_q;
    tick_count_d  = tick_count_q;
    spike_count_d = spike_count_q;

    if (counting && packet_out_valid && (spike_count_q != {CNT_W{1'b1}})) begin
      spike_count_d = spike_count_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start && config_ready_q && !clear_error) begin
          num_ticks_d   = num_ticks;
          period_d      = tick_period;
          tick_count_d  = '0;
          spike_count_d = '0;
          state_d       = (num_ticks == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (run_err) begin
          state_d = S_ERROR;
        end else if (input_buffer_empty && !ren_to_input_buffer) begin
          state_d = S_TICK;
        end
      end
      S_TICK: begin
        // The pulse is already on the wire this cycle, so it is counted even on error.
        tick_count_d = tick_count_q + CNT_W'(1);
        wait_cnt_d   = (period_q == '0) ? CNT_W'(1) : period_q;
        state_d      = run_err ? S_ERROR : S_WAIT;
      end
      S_WAIT: begin
        if (run_err) begin
          state_d = S_ERROR;
        end else if (wait_cnt_q == CNT_W'(1)) begin
          state_d = (tick_count_q == num_ticks_q) ? S_DONE : S_DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (clear_error) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      num_ticks_q    <= '0;
      period_q       <= '0;
      wait_cnt_q     <= '0;
      tick_count_q   <= '0;
      spike_count_q  <= '0;
      param_loaded_q <= 1'b0;
      inst_loaded_q  <= 1'b0;
      config_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_ticks_q    <= num_ticks_d;
      period_q       <= period_d;
      wait_cnt_q     <= wait_cnt_d;
      tick_count_q   <= tick_count_d;
      spike_count_q  <= spike_count_d;
      param_loaded_q <= param_loaded_d;
      inst_loaded_q  <= inst_loaded_d;
      config_ready_q <= config_ready_d;
    end
  end

  assign tick         = (state_q == S_TICK);
  assign busy         = (state_q == S_DRAIN) || (state_q == S_TICK) || (state_q == S_WAIT);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign config_ready = config_ready_q;
  assign tick_count   = tick_count_q;
  assign spike_count  = spike_count_q;

endmodule

// File: tb/tb_snn_tick_scheduler.sv
// Directed bench for snn_tick_scheduler: config tracking, tick timing, drain stalls,
// zero-tick runs, error abort/clear, spike saturation and mid-run reset.
module tb_snn_tick_scheduler;

  localparam int NN    = 256;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             clear_error;
  logic [CNT_W-1:0] num_ticks;
  logic [CNT_W-1:0] tick_period;
  logic             param_wen;
  logic [7:0]       param_address;
  logic             neuron_inst_wen;
  logic [7:0]       neuron_inst_address;
  logic             input_buffer_empty;
  logic             ren_to_input_buffer;
  logic             packet_out_valid;
  logic             token_controller_error;
  logic             scheduler_error;
  logic             tick;
  logic             config_ready;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] tick_count;
  logic [CNT_W-1:0] spike_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  snn_tick_scheduler #(.NUM_NEURONS(NN), .CNT_W(CNT_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .clear_error            (clear_error),
    .num_ticks              (num_ticks),
    .tick_period            (tick_period),
    .param_wen              (param_wen),
    .param_address          (param_address),
    .neuron_inst_wen        (neuron_inst_wen),
    .neuron_inst_address    (neuron_inst_address),
    .input_buffer_empty     (input_buffer_empty),
    .ren_to_input_buffer    (ren_to_input_buffer),
    .packet_out_valid       (packet_out_valid),
    .token_controller_error (token_controller_error),
    .scheduler_error        (scheduler_error),
    .tick                   (tick),
    .config_ready           (config_ready),
    .busy                   (busy),
    .done                   (done),
    .error                  (error),
    .tick_count             (tick_count),
    .spike_count            (spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Inputs change only at the negedge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] p);
    num_ticks   = n;
    tick_period = p;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  initial begin
    int s, t1, t2, t3, d, nt;

    reset = 1'b1; start = 0; clear_error = 0; num_ticks = 0; tick_period = 0;
    param_wen = 0; param_address = 0; neuron_inst_wen = 0; neuron_inst_address = 0;
    input_buffer_empty = 1; ren_to_input_buffer = 0; packet_out_valid = 0;
    token_controller_error = 0; scheduler_error = 0;
    @(negedge clk);
    step();
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, error, config_ready}, 0);
    chk("rst_counts", {tick_count, spike_count}, 0);
    reset = 1'b0;
    step();

    // Start before configuration is ignored.
    pulse_start(16'd3, 16'd4);
    chk("unconf_busy", busy, 0);
    nt = 0;
    repeat (5) begin step(); if (tick) nt++; end
    chk("unconf_ticks", nt, 0);

    // Config tracking: only address 255 of both memories completes loading.
    neuron_inst_wen = 1; neuron_inst_address = 8'd254; step();
    param_wen = 1; neuron_inst_wen = 0; param_address = 8'd255; step();
    param_wen = 0;
    chk("cfg_param_only", config_ready, 0);
    neuron_inst_wen = 1; neuron_inst_address = 8'd255; step();
    neuron_inst_wen = 0;
    chk("cfg_ready", config_ready, 1);

    // Run 1: 3 ticks, period 4 -> spacing 6, done 5 cycles after last tick.
    pulse_start(16'd3, 16'd4);
    s = cyc;
    chk("r1_busy", busy, 1);
    wait_tick(20, t1);
    chk("r1_t1", t1 - s, 1);
    step();
    chk("r1_tick_width", tick, 0);
    wait_tick(20, t2);
    chk("r1_t2_spacing", t2 - t1, 6);
    wait_tick(20, t3);
    chk("r1_t3_spacing", t3 - t2, 6);
    wait_done(20, d);
    chk("r1_done_lat", d - t3, 5);
    chk("r1_tick_count", tick_count, 3);
    chk("r1_done_busy", busy, 0);
    step();
    chk("r1_done_width", done, 0);

    // Run 2: input buffer stall (empty low 10 cycles, then one cycle of ren).
    pulse_start(16'd3, 16'd4);
    wait_tick(20, t1);
    input_buffer_empty = 0;
    repeat (10) step();
    input_buffer_empty = 1; ren_to_input_buffer = 1;
    step();
    ren_to_input_buffer = 0;
    wait_tick(20, t2);
    chk("r2_t2_stalled", t2 - t1, 12);
    wait_tick(20, t3);
    chk("r2_t3_spacing", t3 - t2, 6);
    wait_done(20, d);
    chk("r2_done_lat", d - t3, 5);
    chk("r2_tick_count", tick_count, 3);

    // Zero-tick run: done the cycle after start.
    step();
    pulse_start(16'd0, 16'd4);
    chk("z_done", done, 1);
    chk("z_tick_busy", {tick, busy}, 0);
    chk("z_tick_count", tick_count, 0);
    step();
    chk("z_done_width", done, 0);

    // Error in WAIT aborts; start ignored; clear returns to IDLE.
    pulse_start(16'd5, 16'd4);
    wait_tick(20, t1);
    step(); step();
    scheduler_error = 1; step(); scheduler_error = 0;
    chk("e_error", error, 1);
    chk("e_busy", busy, 0);
    chk("e_tick_count", tick_count, 1);
    pulse_start(16'd1, 16'd1);
    chk("e_start_ignored", error, 1);
    nt = 0;
    repeat (10) begin step(); if (tick) nt++; end
    chk("e_no_ticks", nt, 0);
    clear_error = 1; step(); clear_error = 0;
    chk("e_cleared", error, 0);
    // clear_error wins over a simultaneous start in IDLE.
    clear_error = 1; pulse_start(16'd1, 16'd1); clear_error = 0;
    chk("e_clear_beats_start", {busy, done}, 0);

    // Normal run after clear with period 0 (treated as 1).
    pulse_start(16'd1, 16'd0);
    s = cyc;
    wait_tick(10, t1);
    chk("p0_t1", t1 - s, 1);
    wait_done(10, d);
    chk("p0_done_lat", d - t1, 2);
    chk("p0_tick_count", tick_count, 1);
    step();

    // Long stalled run: spike saturation, start while busy ignored, param_wen aborts.
    input_buffer_empty = 0;
    pulse_start(16'd1, 16'd2);
    packet_out_valid = 1;
    repeat (100) step();
    chk("sat_partial", spike_count, 100);
    pulse_start(16'd0, 16'd2);
    chk("sat_start_ignored", busy, 1);
    nt = 0;
    repeat (69899) begin step(); if (tick) nt++; end
    chk("sat_no_ticks", nt, 0);
    chk("sat_value", spike_count, 65535);
    chk("sat_busy", busy, 1);
    packet_out_valid = 0;
    param_wen = 1; param_address = 8'd0; step(); param_wen = 0;
    chk("cfgmod_error", error, 1);
    chk("cfgmod_counts", {tick_count, spike_count}, {16'd0, 16'd65535});
    input_buffer_empty = 1;
    clear_error = 1; step(); clear_error = 0;

    // Asynchronous reset mid-run clears everything including config.
    pulse_start(16'd4, 16'd3);
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cfg", config_ready, 0);
    step();
    reset = 1'b0;
    pulse_start(16'd2, 16'd2);
    chk("arst_needs_reload", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_tick_scheduler.md
Name: snn_tick_scheduler

Overview:
- Run-time sequencer for the 1x1 RANC SNN core, in the core clock domain.
- Monitors the parameter and neuron-instruction write ports driven by the load FIFOs and declares the core configured once both memories are fully loaded.
- After a start command, issues a programmed number of tick pulses. Before each tick it waits for the input buffer to drain, and it enforces a minimum tick spacing.
- Counts output spikes and aborts the run on any core error.

Parameters:
- NUM_NEURONS, 256, depth of the param and neuron-instruction memories; the last address is NUM_NEURONS-1.
- CNT_W, 16, width of num_ticks, tick_period, tick_count and spike_count.

Ports:
- clk  in  1  core clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request.
- clear_error  in  1  one-cycle clear of the ERROR state.
- num_ticks  in  CNT_W  ticks per run; sampled on accepted start.
- tick_period  in  CNT_W  minimum WAIT cycles after a tick; sampled on accepted start.
- param_wen  in  1  core param memory write enable (monitored).
- param_address  in  $clog2(NUM_NEURONS)  core param write address.
- neuron_inst_wen  in  1  core neuron-instruction write enable.
- neuron_inst_address  in  $clog2(NUM_NEURONS)  neuron-instruction write address.
- input_buffer_empty  in  1  input packet buffer empty.
- ren_to_input_buffer  in  1  core is reading the input buffer.
- packet_out_valid  in  1  core emitted a spike packet.
- token_controller_error  in  1  core error.
- scheduler_error  in  1  core error.
- tick  out  1  tick pulse to the core.
- config_ready  out  1  both memories fully loaded.
- busy  out  1  run in progress (DRAIN, TICK or WAIT).
- done  out  1  one-cycle run-complete pulse.
- error  out  1  run aborted (ERROR state).
- tick_count  out  CNT_W  ticks issued in the current or last run.
- spike_count  out  CNT_W  packet_out_valid count in the current or last run; saturating.

Behaviour:

Reset:
- All outputs 0, state IDLE, all internal flags and counters 0.

Config tracking:
- param_loaded sets on param_wen && param_address==NUM_NEURONS-1.
- inst_loaded sets on neuron_inst_wen && neuron_inst_address==NUM_NEURONS-1.
- config_ready = param_loaded & inst_loaded, registered (visible the cycle after the setting write).
- Flags clear only on reset; reloading does not clear them.

FSM states: IDLE, DRAIN, TICK, WAIT, DONE, ERROR. All outputs are registered or decoded from state.
- IDLE: start && config_ready && !clear_error moves the FSM as follows.
  - Latch num_ticks and tick_period; clear tick_count and spike_count.
  - If num_ticks==0, go to DONE; otherwise go to DRAIN.
  - start while !config_ready is ignored with no side effects.
- DRAIN: stay until input_buffer_empty && !ren_to_input_buffer in the same cycle, then go to TICK. Minimum DRAIN length is 1 cycle.
- TICK: tick=1 for exactly this cycle; tick_count+1; load the period counter with max(tick_period,1); go to WAIT.
- WAIT: decrement the counter each cycle and leave when it is 1, so WAIT lasts P=max(tick_period,1) cycles.
  - If tick_count==latched num_ticks, go to DONE; otherwise go to DRAIN.
  - Consecutive ticks are therefore at least P+2 cycles apart.
- DONE: done=1 for one cycle; go to IDLE.
- ERROR: error=1, tick=0. Hold until clear_error, then go to IDLE. Counters retain their values until the next start.

busy:
- busy=1 in DRAIN, TICK and WAIT; 0 elsewhere.

Error entry (from DRAIN, TICK or WAIT), any of:
- token_controller_error or scheduler_error sampled high;
- param_wen or neuron_inst_wen asserted (configuration modified mid-run).

Error entry rules:
- Error entry takes priority over every other transition in that cycle, including a TICK that would otherwise occur.
- A tick already issued in a TICK state is not retracted.
- Errors are ignored in IDLE and DONE.

spike_count:
- Increments on packet_out_valid in DRAIN, TICK, WAIT and DONE. Saturates at 2^CNT_W-1.

Other rules:
- start while busy, or in DONE or ERROR, is ignored.
- clear_error and start in the same cycle: clear wins and start is dropped.
- tick_count never exceeds latched num_ticks.
- num_ticks = 2^CNT_W-1 is legal; no wrap.
- Reset asserted mid-run returns the block to IDLE immediately and clears the config flags, so a reload is required.

Test Plan:
- No loads, pulse start → no tick, busy stays 0. Then write param addr 255 and inst addr 255 → config_ready=1 one cycle after the later write.
- config_ready, num_ticks=3, tick_period=4, input_buffer_empty=1, ren=0, start → exactly 3 single-cycle tick pulses spaced 6 cycles apart, done pulse 5 cycles after the third tick, tick_count=3.
- Same run with input_buffer_empty held 0 for 10 cycles before the second tick → the second tick is delayed until empty && !ren; spacing ≥6.
- num_ticks=0, start → done the cycle after start, no tick, tick_count=0.
- Mid-WAIT scheduler_error pulse → ERROR next cycle, error=1, no further ticks, start ignored. clear_error → IDLE, error=0. A new start runs normally.
- 70000 packet_out_valid pulses during a long run with CNT_W=16 → spike_count saturates at 65535. A param_wen during the run → ERROR.
